conv_encoder_sys: RTL

CONV_ENCODER_SYS -- requirements
Module: conv_encoder_sys

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/conv_encoder_sys.sv | 119 +++++++++++
 2 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and its decoder:
// FSM states, constraint-length limits, generator table and branch-output helper.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

    localparam int K_MIN = 3;
    localparam int K_MAX = 6;
    localparam int SR_W  = K_MAX - 1;

    // Octal generators, right-aligned; bit K-1 taps the current input.
    localparam logic [5:0] GEN_A [K_MIN:K_MAX] = '{6'o07, 6'o17, 6'o35, 6'o75};
    localparam logic [5:0] GEN_B [K_MIN:K_MAX] = '{6'o05, 6'o15, 6'o23, 6'o53};

    function automatic logic [2:0] legal_k(input logic [2:0] k);
        return (k >= 3'(K_MIN) && k <= 3'(K_MAX)) ? k : 3'(K_MIN);
    endfunction

    function automatic logic parity(input logic [5:0] v);
        return ^v;
    endfunction

    // Generators are left-aligned so bit 5 meets the input and lower bits meet
    // progressively older history; taps beyond K-1 fall off as zeros.
    function automatic logic [1:0] branch_out(input logic [2:0] k,
                                              input logic din,
                                              input logic [SR_W-1:0] sr);
        logic [5:0] taps;
        logic [2:0] shift;
        taps  = {din, sr[0], sr[1], sr[2], sr[3], sr[4]};
        shift = 3'(K_MAX) - k;
        return {parity((GEN_A[k] << shift) & taps),
                parity((GEN_B[k] << shift) & taps)};
    endfunction

endpackage

// File: rtl/conv_encoder_sys.sv
// Rate-1/2 feed-forward convolutional encoder, K selectable 3..6 per frame,
// with zero-tail flushing and valid/ready handshakes on both sides.
import conv_pkg::*;

module conv_encoder_sys (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] choose_constraint_length,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] encoded_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    state_t            state_reg, state_next;
    logic [SR_W-1:0]   sr_reg, sr_next;
    logic [2:0]        tail_cnt_reg, tail_cnt_next;
    logic [2:0]        k_reg, k_next;
    logic [1:0]        enc_reg, enc_next;
    logic              out_valid_reg, out_valid_next;
    logic              out_last_reg, out_last_next;

    logic              slot_free;
    logic              accept;
    logic [2:0]        k_use;
    logic [1:0]        sym_in;
    logic [1:0]        sym_tail;

    // The output register can take a new symbol when empty or draining this cycle.
    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = (state_reg != TAIL) && slot_free;
    assign accept    = in_valid && in_ready;
    assign k_use     = (state_reg == IDLE) ? legal_k(choose_constraint_length) : k_reg;
    assign sym_in    = branch_out(k_use, in_bit, sr_reg);
    assign sym_tail  = branch_out(k_reg, 1'b0, sr_reg);

    assign encoded_bits = enc_reg;
    assign out_valid    = out_valid_reg;
    assign out_last     = out_last_reg;
    assign busy         = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            sr_reg        <= '0;
            tail_cnt_reg  <= 3'd0;
            k_reg         <= 3'(K_MIN);
            enc_reg       <= 2'b00;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            tail_cnt_reg  <= tail_cnt_next;
            k_reg         <= k_next;
            enc_reg       <= enc_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        tail_cnt_next  = tail_cnt_reg;
        k_next         = k_reg;
        enc_next       = enc_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end

        case (state_reg)
            IDLE, RUN: begin
                if (accept) begin
                    k_next         = k_use;
                    enc_next       = sym_in;
                    out_valid_next = 1'b1;
                    out_last_next  = 1'b0;
                    sr_next        = {sr_reg[SR_W-2:0], in_bit};
                    if (in_last) begin
                        state_next    = TAIL;
                        tail_cnt_next = k_use - 3'd1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    enc_next       = sym_tail;
                    out_valid_next = 1'b1;
                    out_last_next  = (tail_cnt_reg <= 3'd1);
                    sr_next        = {sr_reg[SR_W-2:0], 1'b0};
                    tail_cnt_next  = tail_cnt_reg - 3'd1;
                    // Leave TAIL as the final symbol is issued so the next frame
                    // can start while that symbol is still being handed off.
                    if (tail_cnt_reg <= 3'd1) begin
                        state_next    = IDLE;
                        sr_next       = '0;
                        tail_cnt_next = 3'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
